write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer_if.sv | 38 +++
 rtl/write_buffer.sv | 186 ++++++++++++++++++
 tb/tb_write_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/write_buffer_if.sv
// Signal bundle joining the upstream CPU port, the posted-write buffer and
// the memory controller. The slave modport is the buffer's own view; the
// master modport is the view of whatever surrounds it (CPU plus memory).
interface write_buffer_if;
   logic        cpu_stb;
   logic        cpu_we;
   logic [26:0] cpu_addr;
   logic [31:0] cpu_din;
   logic [31:0] cpu_dout;
   logic        cpu_ack;
   logic        cpu_timeout;

   logic        mem_stb;
   logic        mem_we;
   logic [26:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        mem_ack;
   logic        mem_timeout;

   logic        wr_err;

   modport slave (
      input  cpu_stb, cpu_we, cpu_addr, cpu_din,
      output cpu_dout, cpu_ack, cpu_timeout,
      output mem_stb, mem_we, mem_addr, mem_dout,
      input  mem_din, mem_ack, mem_timeout,
      output wr_err
   );

   modport master (
      output cpu_stb, cpu_we, cpu_addr, cpu_din,
      input  cpu_dout, cpu_ack, cpu_timeout,
      input  mem_stb, mem_we, mem_addr, mem_dout,
      output mem_din, mem_ack, mem_timeout,
      input  wr_err
   );
endinterface

// File: rtl/write_buffer.sv
// Posted-write buffer between a CPU port and a memory controller.
// Writes are acknowledged as soon as they land in a DEPTH-entry FIFO and are
// drained to memory in order. Reads are only issued once the FIFO is empty,
// which gives read-after-write ordering without any forwarding path. A GAP
// state after every memory transaction keeps mem_stb low for one cycle.
module write_buffer #(
   parameter int DEPTH = 4   // power of two, 2..16
) (
   input  logic          clk,
   input  logic          rst,
   write_buffer_if.slave bus
);

   localparam int ADDR_W = 27;
   localparam int DATA_W = 32;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   // FIFO storage and bookkeeping
   logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
   logic [DATA_W-1:0] r_fifo_data [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;

   // Controller state and registered outputs
   state_t            r_state;
   logic              r_cpu_ack;
   logic              r_cpu_timeout;
   logic [DATA_W-1:0] r_cpu_dout;
   logic              r_mem_stb;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_dout;
   logic              r_wr_err;

   // Decoded conditions
   logic              w_cpu_busy;
   logic              w_push;
   logic              w_rd_req;
   logic              w_mem_done;
   logic              w_pop;
   logic              w_fifo_empty;
   logic [ADDR_W-1:0] w_head_addr;
   logic [DATA_W-1:0] w_head_data;

   // A cycle that is already answering the CPU must not accept the same
   // still-asserted strobe a second time.
   assign w_cpu_busy   = r_cpu_ack | r_cpu_timeout;

   // The fullness test uses the registered count, so a slot freed by a pop
   // only becomes visible to the CPU one cycle later.
   assign w_push       = bus.cpu_stb & bus.cpu_we & ~w_cpu_busy & (r_count < C_FULL);
   assign w_rd_req     = bus.cpu_stb & ~bus.cpu_we & ~w_cpu_busy;

   // Memory responses matter only while a transaction is outstanding.
   assign w_mem_done   = bus.mem_ack | bus.mem_timeout;
   assign w_pop        = (r_state == S_WRITE) & w_mem_done;

   assign w_fifo_empty = (r_count == '0);
   assign w_head_addr  = r_fifo_addr[r_rd_ptr];
   assign w_head_data  = r_fifo_data[r_rd_ptr];

   // Capture each accepted write into the slot at the write pointer.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= bus.cpu_addr;
         r_fifo_data[r_wr_ptr] <= bus.cpu_din;
      end
   end

   // Advance pointers and occupancy on push/pop; pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sequence memory transactions and drive every CPU/memory output from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cpu_ack     <= 1'b0;
         r_cpu_timeout <= 1'b0;
         r_cpu_dout    <= '0;
         r_mem_stb     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_dout    <= '0;
         r_wr_err      <= 1'b0;
      end else begin
         // Acks and timeouts are single-cycle pulses unless re-armed below.
         r_cpu_ack     <= w_push;
         r_cpu_timeout <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (!w_fifo_empty) begin
                  // Drain the oldest posted write; it is held stable until
                  // the controller answers.
                  r_state    <= S_WRITE;
                  r_mem_stb  <= 1'b1;
                  r_mem_we   <= 1'b1;
                  r_mem_addr <= w_head_addr;
                  r_mem_dout <= w_head_data;
               end else if (w_rd_req) begin
                  // Reads go out only with the FIFO empty, so every earlier
                  // write has already completed at the memory.
                  r_state    <= S_READ;
                  r_mem_stb  <= 1'b1;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= bus.cpu_addr;
               end
            end

            S_WRITE: begin
               if (w_mem_done) begin
                  r_state   <= S_GAP;
                  r_mem_stb <= 1'b0;
                  r_mem_we  <= 1'b0;
                  // Ack wins when both arrive together.
                  if (bus.mem_timeout && !bus.mem_ack) begin
                     r_wr_err <= 1'b1;
                  end
               end
            end

            S_READ: begin
               if (bus.mem_ack) begin
                  r_state    <= S_GAP;
                  r_mem_stb  <= 1'b0;
                  r_cpu_dout <= bus.mem_din;
                  r_cpu_ack  <= 1'b1;
               end else if (bus.mem_timeout) begin
                  // Read data is left untouched on a timeout.
                  r_state       <= S_GAP;
                  r_mem_stb     <= 1'b0;
                  r_cpu_timeout <= 1'b1;
               end
            end

            S_GAP: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state   <= S_IDLE;
               r_mem_stb <= 1'b0;
               r_mem_we  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_ack     = r_cpu_ack;
   assign bus.cpu_timeout = r_cpu_timeout;
   assign bus.cpu_dout    = r_cpu_dout;
   assign bus.mem_stb     = r_mem_stb;
   assign bus.mem_we      = r_mem_we;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_dout    = r_mem_dout;
   assign bus.wr_err      = r_wr_err;

endmodule

// File: tb/tb_write_buffer.sv
// Directed bench for write_buffer: a CPU-side driver in one initial block and
// a memory responder that checks every transaction against a scoreboard.
`timescale 1ns/1ps
module tb_write_buffer;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [26:0] addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [26:0] addr;
      logic [31:0] data;
      int          mode;   // 0 ack, 1 timeout, 2 ack+timeout together
   } rd_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   cyc;

   write_buffer_if bus();

   write_buffer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Scoreboard and responder state
   wr_t         wq[$];
   rd_t         rq[$];
   int          mem_lat;
   int          wr_mode;
   bit          in_txn;
   bit          responded;
   int          wcnt;
   int          starts;
   int          wr_done;
   int          start_cyc;
   int          drv_cyc;
   bit          cur_we;
   int          cur_mode;
   logic [26:0] cur_addr;
   logic [31:0] cur_data;
   logic [31:0] cur_rdata;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory controller model: checks each request, answers after mem_lat cycles.
   always @(negedge clk) begin
      if (rst) begin
         bus.mem_ack     = 1'b0;
         bus.mem_timeout = 1'b0;
         bus.mem_din     = '0;
         in_txn          = 1'b0;
         responded       = 1'b0;
      end else begin
         bus.mem_ack     = 1'b0;
         bus.mem_timeout = 1'b0;
         if (responded) begin
            check("mem_stb_drop", 64'(bus.mem_stb), 64'(0));
            responded = 1'b0;
            in_txn    = 1'b0;
         end else if (!bus.mem_stb) begin
            in_txn = 1'b0;
         end else begin
            if (!in_txn) begin
               in_txn    = 1'b1;
               wcnt      = 0;
               starts++;
               start_cyc = cyc;
               cur_we    = bus.mem_we;
               cur_addr  = bus.mem_addr;
               cur_data  = bus.mem_dout;
               cur_rdata = 32'hFFFF_0000;
               cur_mode  = 0;
               if (bus.mem_we) begin
                  cur_mode = wr_mode;
                  if (wq.size() == 0) begin
                     check("mem_wr_unexpected", 64'(bus.mem_stb), 64'(0));
                  end else begin
                     wr_t e;
                     e = wq.pop_front();
                     check("mem_wr_addr", 64'(bus.mem_addr), 64'(e.addr));
                     check("mem_wr_data", 64'(bus.mem_dout), 64'(e.data));
                  end
               end else begin
                  check("rd_after_drain", 64'(wq.size()), 64'(0));
                  if (rq.size() == 0) begin
                     check("mem_rd_unexpected", 64'(bus.mem_stb), 64'(0));
                  end else begin
                     rd_t r;
                     r = rq.pop_front();
                     check("mem_rd_addr", 64'(bus.mem_addr), 64'(r.addr));
                     cur_mode  = r.mode;
                     cur_rdata = r.data;
                  end
               end
            end else begin
               wcnt++;
               check("mem_addr_stable", 64'(bus.mem_addr), 64'(cur_addr));
               check("mem_we_stable", 64'(bus.mem_we), 64'(cur_we));
               if (cur_we) begin
                  check("mem_dout_stable", 64'(bus.mem_dout), 64'(cur_data));
               end
            end
            if (wcnt >= mem_lat) begin
               case (cur_mode)
                  1: bus.mem_timeout = 1'b1;
                  2: begin
                     bus.mem_ack     = 1'b1;
                     bus.mem_timeout = 1'b1;
                  end
                  default: bus.mem_ack = 1'b1;
               endcase
               bus.mem_din = (cur_mode == 1) ? 32'hBAD0_BAD0 : cur_rdata;
               responded   = 1'b1;
               if (cur_we) wr_done++;
            end
         end
      end
   end

   task automatic cpu_write(input logic [26:0] a, input logic [31:0] d, output int lat);
      wr_t e;
      e.addr = a;
      e.data = d;
      wq.push_back(e);
      drv_cyc      = cyc;
      bus.cpu_stb  = 1'b1;
      bus.cpu_we   = 1'b1;
      bus.cpu_addr = a;
      bus.cpu_din  = d;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.cpu_ack && lat < 200);
      check("wr_ack", 64'(bus.cpu_ack), 64'(1));
      bus.cpu_stb = 1'b0;
      bus.cpu_we  = 1'b0;
      @(negedge clk);
      check("wr_ack_pulse", 64'(bus.cpu_ack), 64'(0));
   endtask

   task automatic cpu_read(input logic [26:0] a, input logic [31:0] d, input int mode);
      rd_t         e;
      logic [31:0] prev;
      int          n;
      e.addr = a;
      e.data = d;
      e.mode = mode;
      rq.push_back(e);
      prev         = bus.cpu_dout;
      bus.cpu_stb  = 1'b1;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = a;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.cpu_ack && !bus.cpu_timeout && n < 300);
      if (mode == 1) begin
         check("rd_timeout", 64'(bus.cpu_timeout), 64'(1));
         check("rd_timeout_noack", 64'(bus.cpu_ack), 64'(0));
         check("rd_timeout_dout", 64'(bus.cpu_dout), 64'(prev));
      end else begin
         check("rd_ack", 64'(bus.cpu_ack), 64'(1));
         check("rd_no_timeout", 64'(bus.cpu_timeout), 64'(0));
         check("rd_data", 64'(bus.cpu_dout), 64'(d));
      end
      bus.cpu_stb = 1'b0;
      @(negedge clk);
      check("rd_end_ack", 64'(bus.cpu_ack), 64'(0));
      check("rd_end_timeout", 64'(bus.cpu_timeout), 64'(0));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((wq.size() != 0 || in_txn || bus.mem_stb) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("drain_stb", 64'(bus.mem_stb), 64'(0));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "watchdog");
   end

   int lat;
   int s0;
   int d0;
   int n;

   initial begin
      total = 0; bad = 0; cyc = 0;
      mem_lat = 1; wr_mode = 0;
      in_txn = 0; responded = 0; wcnt = 0; starts = 0; wr_done = 0;
      start_cyc = 0; drv_cyc = 0;
      bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_mem_stb", 64'(bus.mem_stb), 64'(0));
      check("rst_mem_we", 64'(bus.mem_we), 64'(0));
      check("rst_cpu_ack", 64'(bus.cpu_ack), 64'(0));
      check("rst_cpu_timeout", 64'(bus.cpu_timeout), 64'(0));
      check("rst_wr_err", 64'(bus.wr_err), 64'(0));
      check("rst_cpu_dout", 64'(bus.cpu_dout), 64'(0));
      check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
      check("rst_mem_dout", 64'(bus.mem_dout), 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single write
      s0 = starts;
      cpu_write(27'h000_0010, 32'hDEAD_BEEF, lat);
      check("t1_ack_latency", 64'(lat), 64'(1));
      n = 0;
      while (starts == s0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t1_mem_started", 64'(starts - s0), 64'(1));
      check("t1_stb_within_2", 64'(start_cyc - drv_cyc <= 2), 64'(1));
      wait_drain();
      for (int i = 0; i < 3; i++) begin
         check("t1_stays_idle", 64'(bus.mem_stb), 64'(0));
         @(negedge clk);
      end

      // Five back-to-back writes against a slow memory
      mem_lat = 20;
      d0 = wr_done;
      for (int i = 0; i < 5; i++) begin
         cpu_write(27'h000_0100 + 27'(i), 32'hA000_0000 + 32'(i), lat);
         if (i < DEPTH) begin
            check("t2_ack_latency", 64'(lat), 64'(1));
         end else begin
            check("t2_fifth_stalled", 64'(lat > 1), 64'(1));
            check("t2_fifth_after_pop", 64'(wr_done - d0 >= 1), 64'(1));
         end
      end
      wait_drain();
      check("t2_all_drained", 64'(wr_done - d0), 64'(5));

      // Two writes followed by a read of the second address
      mem_lat = 2;
      cpu_write(27'h000_0200, 32'h1111_1111, lat);
      cpu_write(27'h000_0201, 32'h2222_2222, lat);
      cpu_read(27'h000_0201, 32'h1234_5678, 0);
      wait_drain();

      // Read timeout, then write timeout making wr_err sticky
      cpu_read(27'h000_0300, 32'h0000_0000, 1);
      check("t4_wr_err_after_rd_to", 64'(bus.wr_err), 64'(0));
      wait_drain();
      wr_mode = 1;
      cpu_write(27'h000_0301, 32'hCAFE_F00D, lat);
      wait_drain();
      check("t4_wr_err_set", 64'(bus.wr_err), 64'(1));
      wr_mode = 0;
      cpu_write(27'h000_0302, 32'h0BAD_CAFE, lat);
      wait_drain();
      check("t4_wr_err_sticky", 64'(bus.wr_err), 64'(1));

      // Reset with three entries buffered and a write in flight
      mem_lat = 50;
      cpu_write(27'h000_0400, 32'h4000_0000, lat);
      cpu_write(27'h000_0401, 32'h4000_0001, lat);
      cpu_write(27'h000_0402, 32'h4000_0002, lat);
      check("t5_stb_before_rst", 64'(bus.mem_stb), 64'(1));
      #2;
      rst = 1'b1;
      #1;
      check("t5_rst_mem_stb", 64'(bus.mem_stb), 64'(0));
      check("t5_rst_mem_we", 64'(bus.mem_we), 64'(0));
      check("t5_rst_wr_err", 64'(bus.wr_err), 64'(0));
      check("t5_rst_cpu_dout", 64'(bus.cpu_dout), 64'(0));
      check("t5_rst_mem_addr", 64'(bus.mem_addr), 64'(0));
      check("t5_rst_mem_dout", 64'(bus.mem_dout), 64'(0));
      wq.delete();
      @(negedge clk);
      rst = 1'b0;
      s0 = starts;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t5_quiet_stb", 64'(bus.mem_stb), 64'(0));
         check("t5_quiet_ack", 64'(bus.cpu_ack), 64'(0));
      end
      check("t5_no_new_txn", 64'(starts - s0), 64'(0));
      mem_lat = 1;
      cpu_write(27'h000_0410, 32'h4100_0000, lat);
      wait_drain();
      check("t5_new_write_txn", 64'(starts - s0), 64'(1));

      // Ack and timeout together count as ack
      wr_mode = 2;
      cpu_write(27'h000_0500, 32'h5000_0000, lat);
      wait_drain();
      check("t6_wr_err_clear", 64'(bus.wr_err), 64'(0));
      wr_mode = 0;
      cpu_read(27'h000_0500, 32'h55AA_55AA, 2);
      wait_drain();

      // Pointer wrap: ten writes with immediate memory ack
      mem_lat = 0;
      s0 = starts;
      for (int i = 0; i < 10; i++) begin
         cpu_write(27'h000_0600 + 27'(i), 32'h0F00_0000 + 32'(i) * 32'h0101_0101, lat);
      end
      wait_drain();
      check("t7_ten_txns", 64'(starts - s0), 64'(10));
      check("t7_queue_empty", 64'(wq.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
